// File: rtl/instr_fetch.sv
// Fetch stage: in-order imem reads into a prefetch FIFO, presenting current + look-ahead word to decode.
// Accept at t, rvalid at t+1 gives instr_valid at t+2; requests throttle on FIFO space, stall holds the head.
module instr_fetch #(
   parameter int                    ADDR_WIDTH = 16,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
   parameter int                    BUF_DEPTH  = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic                  imem_req,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   input  logic                  imem_ready,
   input  logic                  imem_rvalid,
   input  logic [31:0]           imem_rdata,
   input  logic                  redirect,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   input  logic                  stall,
   input  logic                  halt,
   output logic [31:0]           Instruction,
   output logic [31:0]           Instruction_next,
   output logic                  instr_valid,
   output logic                  next_valid,
   output logic [ADDR_WIDTH-1:0] instr_pc,
   output logic                  halted
);
   localparam int          PW  = $clog2(BUF_DEPTH);
   localparam int          CW  = PW + 1;
   localparam logic [31:0] NOP = 32'hC800_0000;

   typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED} state_t;

   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_fetch_pc;
   logic [ADDR_WIDTH-1:0] r_resp_pc;
   logic [CW-1:0]         r_count;
   logic [CW-1:0]         r_outstanding;
   logic [CW-1:0]         r_drop;
   logic [PW-1:0]         r_head;
   logic [PW-1:0]         r_tail;
   logic                  r_halted;
   logic [31:0]           r_buf_word [BUF_DEPTH];
   logic [ADDR_WIDTH-1:0] r_buf_pc   [BUF_DEPTH];

   logic [CW:0]           w_occ;
   logic                  w_run;
   logic                  w_req;
   logic                  w_accept;
   logic                  w_resp;
   logic                  w_push;
   logic                  w_pop;
   logic [CW-1:0]         w_out_nxt;
   logic [PW-1:0]         w_head1;

   // Throttle counts in-flight reads as occupied so a response always finds a free slot.
   assign w_occ     = {1'b0, r_count} + {1'b0, r_outstanding};
   assign w_run     = (r_state == S_RUN) && !redirect && !halt;
   assign w_req     = rst_n && w_run && (w_occ < (CW+1)'(BUF_DEPTH));
   assign w_accept  = w_req && imem_ready;
   assign w_resp    = imem_rvalid && (r_outstanding != '0);
   assign w_push    = w_run && w_resp && (r_drop == '0);
   assign w_pop     = (r_count != '0) && !stall;
   assign w_out_nxt = r_outstanding + CW'(w_accept) - CW'(w_resp);
   assign w_head1   = r_head + PW'(1);

   assign imem_req         = w_req;
   assign imem_addr        = r_fetch_pc;
   assign instr_valid      = (r_count != '0);
   assign next_valid       = (r_count >= CW'(2));
   assign Instruction      = instr_valid ? r_buf_word[r_head]  : NOP;
   assign Instruction_next = next_valid  ? r_buf_word[w_head1] : NOP;
   assign instr_pc         = instr_valid ? r_buf_pc[r_head]    : '0;
   assign halted           = r_halted;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_buf_word[r_tail] <= imem_rdata;
         r_buf_pc[r_tail]   <= r_resp_pc;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_RUN;
         r_fetch_pc    <= RESET_PC;
         r_resp_pc     <= RESET_PC;
         r_count       <= '0;
         r_outstanding <= '0;
         r_drop        <= '0;
         r_head        <= '0;
         r_tail        <= '0;
         r_halted      <= 1'b0;
      end else begin
         r_outstanding <= w_out_nxt;
         case (r_state)
            S_RUN: begin
               if (halt) begin
                  r_state <= S_DRAIN;
                  r_count <= '0;
                  r_head  <= '0;
                  r_tail  <= '0;
                  r_drop  <= '0;
               end else if (redirect) begin
                  // Every read still in flight after this edge belongs to the old path.
                  r_count    <= '0;
                  r_head     <= '0;
                  r_tail     <= '0;
                  r_drop     <= r_outstanding - CW'(w_resp);
                  r_fetch_pc <= redirect_pc;
                  r_resp_pc  <= redirect_pc;
               end else begin
                  if (w_accept)
                     r_fetch_pc <= r_fetch_pc + ADDR_WIDTH'(1);
                  if (w_resp && (r_drop != '0))
                     r_drop <= r_drop - CW'(1);
                  if (w_push) begin
                     r_tail    <= r_tail + PW'(1);
                     r_resp_pc <= r_resp_pc + ADDR_WIDTH'(1);
                  end
                  if (w_pop)
                     r_head <= w_head1;
                  r_count <= r_count + CW'(w_push) - CW'(w_pop);
               end
            end
            S_DRAIN: begin
               r_count <= '0;
               r_head  <= '0;
               r_tail  <= '0;
               r_drop  <= '0;
               if (w_out_nxt == '0) begin
                  r_state  <= S_HALTED;
                  r_halted <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: per-cycle vector table plus throttle, redirect, halt and reset sequences.
module tb_instr_fetch;
   localparam int          AW  = 16;
   localparam logic [31:0] NOP = 32'hC800_0000;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          imem_req;
   logic [AW-1:0] imem_addr;
   logic          imem_ready;
   logic          imem_rvalid;
   logic [31:0]   imem_rdata;
   logic          redirect;
   logic [AW-1:0] redirect_pc;
   logic          stall;
   logic          halt;
   logic [31:0]   Instruction;
   logic [31:0]   Instruction_next;
   logic          instr_valid;
   logic          next_valid;
   logic [AW-1:0] instr_pc;
   logic          halted;

   always #5 clk = ~clk;

   instr_fetch #(.ADDR_WIDTH(AW), .RESET_PC(16'h0000), .BUF_DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall), .halt(halt),
      .Instruction(Instruction), .Instruction_next(Instruction_next),
      .instr_valid(instr_valid), .next_valid(next_valid),
      .instr_pc(instr_pc), .halted(halted)
   );

   typedef struct {
      logic [AW-1:0] addr;
      int            due;
   } mreq_t;

   typedef struct {
      logic          stall;
      logic          rdy;
      logic          req;
      logic [AW-1:0] addr;
      logic          iv;
      logic [31:0]   ins;
      logic [AW-1:0] pc;
      logic          nv;
      logic [31:0]   nxt;
   } vec_t;

   mreq_t mq[$];
   vec_t  tbl[11];
   int    n_chk  = 0;
   int    n_pass = 0;
   int    lat    = 1;
   int    cyc_n  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Memory model: in-order, fixed latency, returns 0xA000_0000 | addr.
   task automatic settle();
      if (mq.size() > 0 && mq[0].due <= cyc_n) begin
         imem_rvalid = 1'b1;
         imem_rdata  = 32'hA000_0000 | {16'h0000, mq[0].addr};
      end else begin
         imem_rvalid = 1'b0;
         imem_rdata  = '0;
      end
      #1;
   endtask

   task automatic tick();
      mreq_t m;
      assert (!(imem_rvalid && mq.size() == 0)) else $error("protocol error: rvalid with nothing outstanding");
      if (imem_rvalid) void'(mq.pop_front());
      if (imem_req && imem_ready) begin
         m.addr = imem_addr;
         m.due  = cyc_n + lat;
         mq.push_back(m);
      end
      @(posedge clk);
      #1;
      cyc_n++;
   endtask

   task automatic check_reset_outs(input string tag);
      chk({tag, ".req"},    imem_req, 0);
      chk({tag, ".addr"},   imem_addr, 0);
      chk({tag, ".instr"},  Instruction, NOP);
      chk({tag, ".next"},   Instruction_next, NOP);
      chk({tag, ".iv"},     instr_valid, 0);
      chk({tag, ".nv"},     next_valid, 0);
      chk({tag, ".pc"},     instr_pc, 0);
      chk({tag, ".halted"}, halted, 0);
   endtask

   // Asserts reset away from any clock edge, checks outputs, releases just after the next edge.
   task automatic async_reset(input string tag);
      rst_n       = 1'b0;
      mq.delete();
      imem_rvalid = 1'b0;
      redirect    = 1'b0;
      halt        = 1'b0;
      stall       = 1'b0;
      imem_ready  = 1'b1;
      #1;
      check_reset_outs(tag);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc_n = 0;
   endtask

   initial begin
      int acc;
      int first_addr;
      int seen;
      int stale;

      tbl[0]  = '{1'b0, 1'b1, 1'b1, 16'd0, 1'b0, NOP,          16'd0, 1'b0, NOP};
      tbl[1]  = '{1'b0, 1'b1, 1'b1, 16'd1, 1'b0, NOP,          16'd0, 1'b0, NOP};
      tbl[2]  = '{1'b1, 1'b1, 1'b1, 16'd2, 1'b1, 32'hA0000000, 16'd0, 1'b0, NOP};
      tbl[3]  = '{1'b0, 1'b1, 1'b1, 16'd3, 1'b1, 32'hA0000000, 16'd0, 1'b1, 32'hA0000001};
      tbl[4]  = '{1'b0, 1'b1, 1'b1, 16'd4, 1'b1, 32'hA0000001, 16'd1, 1'b1, 32'hA0000002};
      tbl[5]  = '{1'b0, 1'b0, 1'b1, 16'd5, 1'b1, 32'hA0000002, 16'd2, 1'b1, 32'hA0000003};
      tbl[6]  = '{1'b0, 1'b0, 1'b1, 16'd5, 1'b1, 32'hA0000003, 16'd3, 1'b1, 32'hA0000004};
      tbl[7]  = '{1'b0, 1'b0, 1'b1, 16'd5, 1'b1, 32'hA0000004, 16'd4, 1'b0, NOP};
      tbl[8]  = '{1'b0, 1'b1, 1'b1, 16'd5, 1'b0, NOP,          16'd0, 1'b0, NOP};
      tbl[9]  = '{1'b0, 1'b1, 1'b1, 16'd6, 1'b0, NOP,          16'd0, 1'b0, NOP};
      tbl[10] = '{1'b0, 1'b1, 1'b1, 16'd7, 1'b1, 32'hA0000005, 16'd5, 1'b0, NOP};

      rst_n       = 1'b0;
      imem_ready  = 1'b1;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      redirect    = 1'b0;
      redirect_pc = '0;
      stall       = 1'b0;
      halt        = 1'b0;
      #2;
      check_reset_outs("rst0");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc_n = 0;

      // Straight line with a stall bubble and a 3-cycle imem_ready backpressure window.
      lat = 1;
      for (int i = 0; i < 11; i++) begin
         stall      = tbl[i].stall;
         imem_ready = tbl[i].rdy;
         settle();
         chk($sformatf("vec%0d.req", i),   imem_req, tbl[i].req);
         chk($sformatf("vec%0d.addr", i),  imem_addr, tbl[i].addr);
         chk($sformatf("vec%0d.iv", i),    instr_valid, tbl[i].iv);
         chk($sformatf("vec%0d.instr", i), Instruction, tbl[i].ins);
         chk($sformatf("vec%0d.pc", i),    instr_pc, tbl[i].pc);
         chk($sformatf("vec%0d.nv", i),    next_valid, tbl[i].nv);
         chk($sformatf("vec%0d.next", i),  Instruction_next, tbl[i].nxt);
         tick();
      end
      settle();
      async_reset("rst1");

      // Throttle: stall held, exactly BUF_DEPTH accepts, then resume at addr 4.
      lat   = 1;
      stall = 1'b1;
      acc   = 0;
      for (int c = 0; c < 10; c++) begin
         settle();
         if (imem_req && imem_ready) acc++;
         tick();
      end
      settle();
      chk("thr.accepts", acc, 4);
      chk("thr.req_off", imem_req, 0);
      chk("thr.instr",   Instruction, 32'hA0000000);
      chk("thr.next",    Instruction_next, 32'hA0000001);
      chk("thr.pc",      instr_pc, 0);
      stall      = 1'b0;
      first_addr = -1;
      for (int c = 0; c < 10; c++) begin
         #1;
         if (first_addr < 0 && imem_req && imem_ready) first_addr = int'(imem_addr);
         tick();
         settle();
      end
      chk("thr.resume_addr", first_addr, 4);
      async_reset("rst2");

      // Redirect with two reads outstanding on a 3-cycle memory.
      lat = 3;
      settle(); tick();
      settle(); tick();
      redirect    = 1'b1;
      redirect_pc = 16'h0040;
      settle();
      chk("rd.req_in_redirect", imem_req, 0);
      tick();
      redirect = 1'b0;
      seen  = 0;
      stale = 0;
      for (int c = 0; c < 20; c++) begin
         settle();
         if (c == 0) chk("rd.addr", imem_addr, 16'h0040);
         if (instr_valid && instr_pc < 16'h0040) stale++;
         if (instr_valid && seen == 0) begin
            seen = 1;
            chk("rd.first_pc",    instr_pc, 16'h0040);
            chk("rd.first_instr", Instruction, 32'hA0000040);
         end
         tick();
      end
      chk("rd.seen",  seen, 1);
      chk("rd.stale", stale, 0);
      async_reset("rst3");

      // Halt together with redirect, one read outstanding on a 3-cycle memory.
      lat = 3;
      settle(); tick();
      halt        = 1'b1;
      redirect    = 1'b1;
      redirect_pc = 16'h0080;
      settle();
      chk("ht.req_drop", imem_req, 0);
      tick();
      halt     = 1'b0;
      redirect = 1'b0;
      settle();
      chk("ht.draining", halted, 0);
      chk("ht.req_c2",   imem_req, 0);
      tick();
      settle();
      chk("ht.last_rvalid", imem_rvalid, 1);
      chk("ht.not_yet",     halted, 0);
      tick();
      settle();
      chk("ht.halted", halted, 1);
      for (int c = 0; c < 8; c++) begin
         redirect = (c % 2 == 0);
         stall    = (c % 3 == 0);
         settle();
         chk($sformatf("ht.stay%0d", c),
             {halted, imem_req, instr_valid, imem_addr}, {1'b1, 1'b0, 1'b0, 16'd1});
         tick();
      end
      redirect = 1'b0;
      stall    = 1'b0;
      settle();
      async_reset("rst4");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got no summary expected summary");
      $fatal(1, "timeout");
   end
endmodule
